writeback_arbiter: RTL and testbench

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/writeback_arbiter.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_writeback_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: three per-source result FIFOs feeding one shared register
// writeback port through a round-robin grant, with registered writeback outputs.

module writeback_arbiter_fifo #(
  parameter int Width = 8,
  parameter int Depth = 2,
  parameter int CntW  = $clog2(Depth) + 1
) (
  input  logic             clock_i,
  input  logic             reset_n_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic [CntW-1:0]  count_o,
  output logic             ready_o
);

  localparam int PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_q;
  logic [PtrW-1:0]  rd_q;
  logic [CntW-1:0]  count_q;
  logic [CntW-1:0]  count_d;

  // Occupancy next state; push and pop together leave the count unchanged.
  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage and pointers; Depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + PtrW'(1);
      end
      if (pop_i) begin
        rd_q <= rd_q + PtrW'(1);
      end
      count_q <= count_d;
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;
  // Ready comes from the registered count only, so a same-cycle pop never raises it.
  assign ready_o = reset_n_i & (count_q < CntW'(Depth));

endmodule

module writeback_arbiter #(
  parameter int         addressSize  = 64,
  parameter int         regWidth     = 5,
  parameter int         fifoDepth    = 2,
  parameter logic [2:0] FXUnitCode   = 3'd0,
  parameter logic [2:0] FPUnitCode   = 3'd1,
  parameter logic [2:0] LdStUnitCode = 3'd2,
  parameter logic [2:0] IdleUnitCode = 3'd7
) (
  input  logic                   clock_i,
  input  logic                   reset_n_i,

  input  logic                   fx_valid_i,
  output logic                   fx_ready_o,
  input  logic                   fx_reg1En_i,
  input  logic                   fx_reg2En_i,
  input  logic [regWidth-1:0]    fx_reg1Addr_i,
  input  logic [regWidth-1:0]    fx_reg2Addr_i,
  input  logic [addressSize-1:0] fx_reg1Data_i,
  input  logic [addressSize-1:0] fx_reg2Data_i,
  input  logic                   fx_is64Bit_i,

  input  logic                   fp_valid_i,
  output logic                   fp_ready_o,
  input  logic                   fp_reg1En_i,
  input  logic                   fp_reg2En_i,
  input  logic [regWidth-1:0]    fp_reg1Addr_i,
  input  logic [regWidth-1:0]    fp_reg2Addr_i,
  input  logic [addressSize-1:0] fp_reg1Data_i,
  input  logic [addressSize-1:0] fp_reg2Data_i,
  input  logic                   fp_is64Bit_i,

  input  logic                   ldst_valid_i,
  output logic                   ldst_ready_o,
  input  logic                   ldst_reg1En_i,
  input  logic                   ldst_reg2En_i,
  input  logic [regWidth-1:0]    ldst_reg1Addr_i,
  input  logic [regWidth-1:0]    ldst_reg2Addr_i,
  input  logic [addressSize-1:0] ldst_reg1Data_i,
  input  logic [addressSize-1:0] ldst_reg2Data_i,
  input  logic                   ldst_is64Bit_i,

  output logic [2:0]             regWritebackFunctionalUnitCode_o,
  output logic                   reg1isWriteback_o,
  output logic                   reg2isWriteback_o,
  output logic [regWidth-1:0]    reg1WritebackAddress_o,
  output logic [regWidth-1:0]    reg2WritebackAddress_o,
  output logic [addressSize-1:0] reg1WritebackData_o,
  output logic [addressSize-1:0] reg2WritebackData_o,
  output logic                   is64Bit_o,
  output logic [3:0]             pendingCount_o
);

  localparam int CntW = $clog2(fifoDepth) + 1;

  typedef struct packed {
    logic                   reg1En;
    logic [regWidth-1:0]    reg1Addr;
    logic [addressSize-1:0] reg1Data;
    logic                   reg2En;
    logic [regWidth-1:0]    reg2Addr;
    logic [addressSize-1:0] reg2Data;
    logic                   is64Bit;
  } entry_t;

  localparam int EntryW = $bits(entry_t);

  // Round-robin pick: returns {valid, index}, searching after the last grant.
  function automatic logic [2:0] rr_pick(input logic [1:0] last, input logic [2:0] ne);
    logic [2:0] pick;
    pick = 3'b000;
    case (last)
      2'd0: begin
        if (ne[1])      pick = 3'b101;
        else if (ne[2]) pick = 3'b110;
        else if (ne[0]) pick = 3'b100;
        else            pick = 3'b000;
      end
      2'd1: begin
        if (ne[2])      pick = 3'b110;
        else if (ne[0]) pick = 3'b100;
        else if (ne[1]) pick = 3'b101;
        else            pick = 3'b000;
      end
      default: begin
        if (ne[0])      pick = 3'b100;
        else if (ne[1]) pick = 3'b101;
        else if (ne[2]) pick = 3'b110;
        else            pick = 3'b000;
      end
    endcase
    return pick;
  endfunction

  function automatic logic [2:0] unit_code(input logic [1:0] idx);
    logic [2:0] code;
    case (idx)
      2'd0:    code = FXUnitCode;
      2'd1:    code = FPUnitCode;
      default: code = LdStUnitCode;
    endcase
    return code;
  endfunction

  entry_t fx_entry_s, fp_entry_s, ldst_entry_s;
  entry_t fx_head_s, fp_head_s, ldst_head_s, head_s;
  logic [CntW-1:0] fx_count_s, fp_count_s, ldst_count_s;
  logic fx_ready_s, fp_ready_s, ldst_ready_s;
  logic fx_push_s, fp_push_s, ldst_push_s;
  logic fx_pop_s, fp_pop_s, ldst_pop_s;
  logic [2:0] nonempty_s;
  logic       grant_valid_s;
  logic [1:0] grant_idx_s;

  logic [1:0]             rr_q, rr_d;
  logic [2:0]             code_q, code_d;
  logic                   wb1_q, wb1_d, wb2_q, wb2_d;
  logic [regWidth-1:0]    addr1_q, addr1_d, addr2_q, addr2_d;
  logic [addressSize-1:0] data1_q, data1_d, data2_q, data2_d;
  logic                   is64_q, is64_d;

  assign fx_entry_s   = {fx_reg1En_i, fx_reg1Addr_i, fx_reg1Data_i,
                         fx_reg2En_i, fx_reg2Addr_i, fx_reg2Data_i, fx_is64Bit_i};
  assign fp_entry_s   = {fp_reg1En_i, fp_reg1Addr_i, fp_reg1Data_i,
                         fp_reg2En_i, fp_reg2Addr_i, fp_reg2Data_i, fp_is64Bit_i};
  assign ldst_entry_s = {ldst_reg1En_i, ldst_reg1Addr_i, ldst_reg1Data_i,
                         ldst_reg2En_i, ldst_reg2Addr_i, ldst_reg2Data_i, ldst_is64Bit_i};

  assign fx_push_s   = fx_valid_i & fx_ready_s;
  assign fp_push_s   = fp_valid_i & fp_ready_s;
  assign ldst_push_s = ldst_valid_i & ldst_ready_s;

  writeback_arbiter_fifo #(.Width(EntryW), .Depth(fifoDepth), .CntW(CntW)) u_fx_fifo (
    .clock_i(clock_i), .reset_n_i(reset_n_i), .push_i(fx_push_s), .data_i(fx_entry_s),
    .pop_i(fx_pop_s), .head_o(fx_head_s), .count_o(fx_count_s), .ready_o(fx_ready_s)
  );

  writeback_arbiter_fifo #(.Width(EntryW), .Depth(fifoDepth), .CntW(CntW)) u_fp_fifo (
    .clock_i(clock_i), .reset_n_i(reset_n_i), .push_i(fp_push_s), .data_i(fp_entry_s),
    .pop_i(fp_pop_s), .head_o(fp_head_s), .count_o(fp_count_s), .ready_o(fp_ready_s)
  );

  writeback_arbiter_fifo #(.Width(EntryW), .Depth(fifoDepth), .CntW(CntW)) u_ldst_fifo (
    .clock_i(clock_i), .reset_n_i(reset_n_i), .push_i(ldst_push_s), .data_i(ldst_entry_s),
    .pop_i(ldst_pop_s), .head_o(ldst_head_s), .count_o(ldst_count_s), .ready_o(ldst_ready_s)
  );

  assign fx_ready_o   = fx_ready_s;
  assign fp_ready_o   = fp_ready_s;
  assign ldst_ready_o = ldst_ready_s;

  // Arbitration sees only registered counts, so a fresh push waits one cycle.
  assign nonempty_s = {(ldst_count_s != '0), (fp_count_s != '0), (fx_count_s != '0)};
  assign {grant_valid_s, grant_idx_s} = rr_pick(rr_q, nonempty_s);

  assign fx_pop_s   = grant_valid_s & (grant_idx_s == 2'd0);
  assign fp_pop_s   = grant_valid_s & (grant_idx_s == 2'd1);
  assign ldst_pop_s = grant_valid_s & (grant_idx_s == 2'd2);

  // Head-of-queue select for the granted source.
  always_comb begin
    head_s = ldst_head_s;
    case (grant_idx_s)
      2'd0:    head_s = fx_head_s;
      2'd1:    head_s = fp_head_s;
      default: head_s = ldst_head_s;
    endcase
  end

  // Writeback register next state; idle cycles keep address/data/mode unchanged.
  always_comb begin
    rr_d    = rr_q;
    code_d  = IdleUnitCode;
    wb1_d   = 1'b0;
    wb2_d   = 1'b0;
    addr1_d = addr1_q;
    addr2_d = addr2_q;
    data1_d = data1_q;
    data2_d = data2_q;
    is64_d  = is64_q;
    if (grant_valid_s) begin
      rr_d    = grant_idx_s;
      code_d  = unit_code(grant_idx_s);
      wb1_d   = head_s.reg1En;
      wb2_d   = head_s.reg2En;
      addr1_d = head_s.reg1Addr;
      addr2_d = head_s.reg2Addr;
      data1_d = head_s.reg1Data;
      data2_d = head_s.reg2Data;
      is64_d  = head_s.is64Bit;
    end else begin
      rr_d   = rr_q;
      code_d = IdleUnitCode;
    end
  end

  // Writeback output and round-robin pointer registers.
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      rr_q    <= 2'd2;
      code_q  <= IdleUnitCode;
      wb1_q   <= 1'b0;
      wb2_q   <= 1'b0;
      addr1_q <= '0;
      addr2_q <= '0;
      data1_q <= '0;
      data2_q <= '0;
      is64_q  <= 1'b0;
    end else begin
      rr_q    <= rr_d;
      code_q  <= code_d;
      wb1_q   <= wb1_d;
      wb2_q   <= wb2_d;
      addr1_q <= addr1_d;
      addr2_q <= addr2_d;
      data1_q <= data1_d;
      data2_q <= data2_d;
      is64_q  <= is64_d;
    end
  end

  assign regWritebackFunctionalUnitCode_o = code_q;
  assign reg1isWriteback_o      = wb1_q;
  assign reg2isWriteback_o      = wb2_q;
  assign reg1WritebackAddress_o = addr1_q;
  assign reg2WritebackAddress_o = addr2_q;
  assign reg1WritebackData_o    = data1_q;
  assign reg2WritebackData_o    = data2_q;
  assign is64Bit_o              = is64_q;
  assign pendingCount_o         = 4'(fx_count_s) + 4'(fp_count_s) + 4'(ldst_count_s);

endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomized and directed bench for writeback_arbiter, checked every cycle
// against a queue-based model of the source FIFOs and round-robin grant.

module tb_writeback_arbiter;

  typedef struct {
    bit          e1;
    logic [4:0]  a1;
    logic [63:0] d1;
    bit          e2;
    logic [4:0]  a2;
    logic [63:0] d2;
    bit          b64;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sv [3];
  logic        se1 [3];
  logic        se2 [3];
  logic        s64 [3];
  logic [4:0]  sa1 [3];
  logic [4:0]  sa2 [3];
  logic [63:0] sd1 [3];
  logic [63:0] sd2 [3];

  logic        rdy [3];
  logic [2:0]  code_o;
  logic        wb1_o, wb2_o, is64_o;
  logic [4:0]  addr1_o, addr2_o;
  logic [63:0] data1_o, data2_o;
  logic [3:0]  pend_o;

  writeback_arbiter dut (
    .clock_i(clk), .reset_n_i(rst_n),
    .fx_valid_i(sv[0]), .fx_ready_o(rdy[0]), .fx_reg1En_i(se1[0]), .fx_reg2En_i(se2[0]),
    .fx_reg1Addr_i(sa1[0]), .fx_reg2Addr_i(sa2[0]), .fx_reg1Data_i(sd1[0]),
    .fx_reg2Data_i(sd2[0]), .fx_is64Bit_i(s64[0]),
    .fp_valid_i(sv[1]), .fp_ready_o(rdy[1]), .fp_reg1En_i(se1[1]), .fp_reg2En_i(se2[1]),
    .fp_reg1Addr_i(sa1[1]), .fp_reg2Addr_i(sa2[1]), .fp_reg1Data_i(sd1[1]),
    .fp_reg2Data_i(sd2[1]), .fp_is64Bit_i(s64[1]),
    .ldst_valid_i(sv[2]), .ldst_ready_o(rdy[2]), .ldst_reg1En_i(se1[2]), .ldst_reg2En_i(se2[2]),
    .ldst_reg1Addr_i(sa1[2]), .ldst_reg2Addr_i(sa2[2]), .ldst_reg1Data_i(sd1[2]),
    .ldst_reg2Data_i(sd2[2]), .ldst_is64Bit_i(s64[2]),
    .regWritebackFunctionalUnitCode_o(code_o),
    .reg1isWriteback_o(wb1_o), .reg2isWriteback_o(wb2_o),
    .reg1WritebackAddress_o(addr1_o), .reg2WritebackAddress_o(addr2_o),
    .reg1WritebackData_o(data1_o), .reg2WritebackData_o(data2_o),
    .is64Bit_o(is64_o), .pendingCount_o(pend_o)
  );

  int checks = 0;
  int failures = 0;

  // Model state: one queue per source, last granted source, expected outputs.
  ent_t mq [3][$];
  int   last_src;
  logic [2:0]  e_code;
  logic        e_wb1, e_wb2, e_64;
  logic [4:0]  e_a1, e_a2;
  logic [63:0] e_d1, e_d2;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 3; s++) mq[s].delete();
    last_src = 2;
    e_code = 3'd7; e_wb1 = 1'b0; e_wb2 = 1'b0; e_64 = 1'b0;
    e_a1 = 5'd0; e_a2 = 5'd0; e_d1 = 64'd0; e_d2 = 64'd0;
  endtask

  task automatic model_step();
    int   sz [3];
    bit   granted;
    int   s;
    ent_t ent;
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int k = 0; k < 3; k++) sz[k] = mq[k].size();
      granted = 1'b0;
      for (int k = 1; k <= 3; k++) begin
        s = (last_src + k) % 3;
        if (!granted && sz[s] > 0) begin
          granted = 1'b1;
          ent = mq[s].pop_front();
          e_code = 3'(s); e_wb1 = ent.e1; e_wb2 = ent.e2; e_64 = ent.b64;
          e_a1 = ent.a1; e_a2 = ent.a2; e_d1 = ent.d1; e_d2 = ent.d2;
          last_src = s;
        end
      end
      if (!granted) begin
        e_code = 3'd7; e_wb1 = 1'b0; e_wb2 = 1'b0;
      end
      for (int k = 0; k < 3; k++) begin
        if (sv[k] && sz[k] < 2) begin
          ent.e1 = se1[k]; ent.a1 = sa1[k]; ent.d1 = sd1[k];
          ent.e2 = se2[k]; ent.a2 = sa2[k]; ent.d2 = sd2[k]; ent.b64 = s64[k];
          mq[k].push_back(ent);
        end
      end
    end
  endtask

  // One clock: compare DUT against model, advance model, cross the edge.
  task automatic cycle();
    int pend;
    #1;
    chk("code", 64'(code_o), 64'(e_code));
    chk("wb1", 64'(wb1_o), 64'(e_wb1));
    chk("wb2", 64'(wb2_o), 64'(e_wb2));
    chk("addr1", 64'(addr1_o), 64'(e_a1));
    chk("addr2", 64'(addr2_o), 64'(e_a2));
    chk("data1", data1_o, e_d1);
    chk("data2", data2_o, e_d2);
    chk("is64", 64'(is64_o), 64'(e_64));
    pend = mq[0].size() + mq[1].size() + mq[2].size();
    chk("pending", 64'(pend_o), 64'(pend));
    for (int s = 0; s < 3; s++)
      chk($sformatf("ready%0d", s), 64'(rdy[s]), 64'(rst_n && mq[s].size() < 2));
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stim();
    for (int s = 0; s < 3; s++) begin
      sv[s] = 1'b0; se1[s] = 1'b0; se2[s] = 1'b0; s64[s] = 1'b0;
      sa1[s] = 5'd0; sa2[s] = 5'd0; sd1[s] = 64'd0; sd2[s] = 64'd0;
    end
  endtask

  task automatic rand_fields(input int s);
    se1[s] = 1'($urandom_range(0, 1));
    se2[s] = 1'($urandom_range(0, 1));
    s64[s] = 1'($urandom_range(0, 1));
    sa1[s] = 5'($urandom);
    sa2[s] = 5'($urandom);
    sd1[s] = {$urandom, $urandom};
    sd2[s] = {$urandom, $urandom};
  endtask

  task automatic push_one(input int s, input bit e1, input logic [4:0] a1,
                          input logic [63:0] d1, input bit e2, input logic [4:0] a2,
                          input logic [63:0] d2);
    sv[s] = 1'b1; se1[s] = e1; sa1[s] = a1; sd1[s] = d1;
    se2[s] = e2; sa2[s] = a2; sd2[s] = d2; s64[s] = 1'b1;
  endtask

  task automatic do_reset();
    clear_stim();
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    int fp_at;
    clear_stim();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_code", 64'(code_o), 64'd7);
    chk("rst_pending", 64'(pend_o), 64'd0);
    chk("rst_ready_forced", 64'(rdy[0] | rdy[1] | rdy[2]), 64'd0);
    cycle();
    rst_n = 1'b1;

    // Single FX push: visible two cycles later, idle after.
    push_one(0, 1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 64'd0);
    cycle();
    clear_stim();
    cycle();
    chk("fx1_code", 64'(code_o), 64'd0);
    chk("fx1_wb1", 64'(wb1_o), 64'd1);
    chk("fx1_addr", 64'(addr1_o), 64'd5);
    chk("fx1_data", data1_o, 64'h1234);
    cycle();
    chk("fx1_idle", 64'(code_o), 64'd7);

    // Two trios of simultaneous pushes: FX, FP, LdSt order each time.
    do_reset();
    for (int t = 0; t < 2; t++) begin
      for (int s = 0; s < 3; s++) push_one(s, 1'b1, 5'(s + 1), 64'(s + 10), 1'b0, 5'd0, 64'd0);
      cycle();
      clear_stim();
      cycle();
      chk("trio_fx", 64'(code_o), 64'd0);
      cycle();
      chk("trio_fp", 64'(code_o), 64'd1);
      cycle();
      chk("trio_ldst", 64'(code_o), 64'd2);
      cycle();
    end

    // Both slots in one LdSt entry.
    push_one(2, 1'b1, 5'd3, 64'd7, 1'b1, 5'd4, 64'd9);
    cycle();
    clear_stim();
    cycle();
    chk("dual_code", 64'(code_o), 64'd2);
    chk("dual_wb", {62'd0, wb1_o, wb2_o}, 64'd3);
    chk("dual_addr", {54'd0, addr1_o, addr2_o}, {54'd0, 5'd3, 5'd4});
    chk("dual_d1", data1_o, 64'd7);
    chk("dual_d2", data2_o, 64'd9);
    cycle();
    chk("dual_idle", 64'(code_o), 64'd7);

    // LdSt backpressure with FX saturating and FP briefly busy.
    do_reset();
    for (int s = 0; s < 3; s++) push_one(s, 1'b0, 5'd1, 64'(s), 1'b1, 5'd2, 64'hA0 + 64'(s));
    cycle();
    chk("bp_ready_c1", 64'(rdy[2]), 64'd1);
    push_one(2, 1'b1, 5'd11, 64'hB, 1'b0, 5'd0, 64'd0);
    cycle();
    chk("bp_ready_c2", 64'(rdy[2]), 64'd0);
    sv[1] = 1'b0;
    push_one(2, 1'b1, 5'd12, 64'hC, 1'b0, 5'd0, 64'd0);
    cycle();
    chk("bp_ready_c3", 64'(rdy[2]), 64'd0);
    cycle();
    chk("bp_ready_c4", 64'(rdy[2]), 64'd1);
    cycle();
    clear_stim();
    for (int i = 0; i < 8; i++) cycle();
    chk("bp_drained", 64'(pend_o), 64'd0);

    // Fill, then reset mid-operation: everything queued is dropped.
    do_reset();
    for (int s = 0; s < 3; s++) push_one(s, 1'b1, 5'd9, 64'hF00 + 64'(s), 1'b1, 5'd8, 64'd1);
    cycle();
    cycle();
    chk("fill_pending", 64'(pend_o), 64'd5);
    clear_stim();
    rst_n = 1'b0;
    cycle();
    chk("mid_rst_pending", 64'(pend_o), 64'd0);
    chk("mid_rst_code", 64'(code_o), 64'd7);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("post_rst_idle", {61'd0, code_o}, 64'd7);
    end

    // FX pushes every cycle, FP once: FP must not starve.
    do_reset();
    fp_at = -1;
    for (int c = 0; c < 12; c++) begin
      clear_stim();
      push_one(0, 1'b1, 5'(c), 64'(c), 1'b0, 5'd0, 64'd0);
      if (c == 3) push_one(1, 1'b1, 5'd20, 64'hF9, 1'b0, 5'd0, 64'd0);
      cycle();
      if (code_o == 3'd1 && fp_at < 0) fp_at = c + 1;
    end
    chk("fp_no_starve_cycle", 64'(fp_at), 64'd5);
    clear_stim();
    for (int i = 0; i < 8; i++) cycle();

    // Random traffic with varying density and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      int density;
      density = (i / 500) % 3;
      rst_n = ($urandom_range(0, 249) != 0);
      for (int s = 0; s < 3; s++) begin
        rand_fields(s);
        sv[s] = (density == 0) ? ($urandom_range(0, 3) == 0) :
                (density == 1) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 7) != 0);
      end
      cycle();
    end
    rst_n = 1'b1;
    clear_stim();
    for (int i = 0; i < 10; i++) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
